// File: rtl/io_pkg.sv
// Shared constants for the data-side memory/I-O bridge: I/O page offsets,
// STATUS register bit positions and the UART transmitter state encoding.
package io_pkg;

    localparam logic [7:0] TXDATA_OFS = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;
    localparam logic [7:0] CYCLE_OFS  = 8'h08;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_FULL_BIT = 1;
    localparam int STAT_OVF_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty detection.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; clearing empties the FIFO immediately.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write for accepted pushes.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_mem_bridge.sv
// Data-side memory stage: word RAM plus an I/O page holding a buffered
// UART transmitter and a free-running cycle counter.
module io_mem_bridge
    import io_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'h0000_FF00
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    logic [31:0]       ram [RAM_WORDS];
    logic              io_sel;
    logic [7:0]        ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       cycle_cnt;
    logic              overflow;
    logic              push_tx;
    logic              ovf_clr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic              pop;

    tx_state_e         state, state_nxt;
    logic [BAUD_W-1:0] baud, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              tx_nxt;
    logic              baud_end;

    assign io_sel   = (addr[31:8] == IO_BASE[31:8]);
    assign ofs      = addr[7:0];
    assign ram_idx  = addr[RAM_AW+1:2];
    assign push_tx  = we && io_sel && (ofs == TXDATA_OFS);
    assign ovf_clr  = we && io_sel && (ofs == STATUS_OFS) && wdata[STAT_OVF_BIT];
    assign baud_end = (baud == BAUD_LAST);
    assign tx_busy  = !fifo_empty || (state != IDLE);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .clear_n (resetn),
        .push    (push_tx),
        .pop     (pop),
        .din     (wdata[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // RAM store; I/O-page accesses never touch the RAM even though the index aliases.
    always_ff @(posedge clock) begin
        if (we && !io_sel) ram[ram_idx] <= wdata;
    end

    // Load data mux: RAM word or I/O register, unmapped offsets read zero.
    always_comb begin
        rdata = '0;
        if (!io_sel) begin
            rdata = ram[ram_idx];
        end else begin
            case (ofs)
                STATUS_OFS: begin
                    rdata[STAT_BUSY_BIT] = tx_busy;
                    rdata[STAT_FULL_BIT] = fifo_full;
                    rdata[STAT_OVF_BIT]  = overflow;
                end
                CYCLE_OFS: rdata = cycle_cnt;
                default:   rdata = '0;
            endcase
        end
    end

    // Free-running cycle counter and sticky overflow flag (drop only when no pop frees a slot).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (push_tx && fifo_full && !pop) overflow <= 1'b1;
            else if (ovf_clr)                 overflow <= 1'b0;
        end
    end

    // Transmitter control registers; tx is registered so the line never glitches.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            tx      <= tx_nxt;
        end
    end

    // Byte shift register holds the frame in flight.
    always_ff @(posedge clock) begin
        shift <= shift_nxt;
    end

    // Next-state logic: tx_nxt is the line level for the coming bit period.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_dout;
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_dout;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_mem_bridge.sv
// Directed bench for io_mem_bridge: RAM, cycle counter, UART framing,
// FIFO overflow and reset during a frame.
module tb_io_mem_bridge;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    int checks   = 0;
    int failures = 0;

    io_mem_bridge #(
        .RAM_WORDS  (64),
        .CLK_DIV    (16),
        .FIFO_DEPTH (4),
        .IO_BASE    (32'h0000_FF00)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Checks one 160-cycle frame; called on the first cycle tx is low.
    task automatic frame(input logic [7:0] b, input string tag);
        for (int k = 0; k < 160; k++) begin
            logic e;
            if (k < 16)       e = 1'b0;
            else if (k < 144) e = b[(k - 16) / 16];
            else              e = 1'b1;
            check(tag, {31'b0, tx}, {31'b0, e});
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c0;
        logic [31:0] c1;
        int          n;

        resetn = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        repeat (3) step();

        // reset state
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_busy", {31'b0, tx_busy}, 32'd0);
        resetn = 1'b1;
        addr   = 32'h0000_FF08;
        #1 check("rst_cycle", rdata, 32'd0);
        addr   = 32'h0000_FF04;
        #1 check("rst_status", rdata, 32'd0);

        // RAM write/read, old value during write, aliasing
        step();
        addr  = 32'h0000_0040;
        wdata = 32'h1111_1111;
        we    = 1'b1;
        step();
        wdata = 32'hDEAD_BEEF;
        #1 check("ram_old", rdata, 32'h1111_1111);
        step();
        we = 1'b0;
        #1 check("ram_rd", rdata, 32'hDEAD_BEEF);
        addr = 32'h0000_0140;
        #1 check("ram_alias", rdata, 32'hDEAD_BEEF);
        addr = 32'h0000_0143;
        #1 check("ram_byteofs", rdata, 32'hDEAD_BEEF);

        // unmapped I/O offset whose index aliases RAM word 0x40
        addr  = 32'h0000_FF40;
        wdata = 32'h1234_5678;
        we    = 1'b1;
        #1 check("io_other_rd", rdata, 32'd0);
        step();
        we   = 1'b0;
        addr = 32'h0000_0040;
        #1 check("ram_kept", rdata, 32'hDEAD_BEEF);
        addr = 32'h0000_FF00;
        #1 check("txdata_rd", rdata, 32'd0);

        // cycle counter: 100 cycles apart, a write in between is ignored
        step();
        addr  = 32'h0000_FF08;
        wdata = 32'd0;
        we    = 1'b1;
        #1 c0 = rdata;
        step();
        we = 1'b0;
        repeat (99) step();
        #1 c1 = rdata;
        check("cyc_delta", c1 - c0, 32'd100);

        // counter wrap
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1 check("cyc_forced", rdata, 32'hFFFF_FFFF);
        release dut.cycle_cnt;
        step();
        #1 check("cyc_wrap", rdata, 32'd0);
        step();
        #1 check("cyc_after_wrap", rdata, 32'd1);

        // single frame of 0x55
        step();
        addr  = 32'h0000_FF00;
        wdata = 32'h0000_0055;
        we    = 1'b1;
        step();
        we   = 1'b0;
        addr = 32'h0000_FF04;
        #1 check("u55_pre_tx", {31'b0, tx}, 32'd1);
        check("u55_pre_status", rdata, 32'd1);
        step();
        frame(8'h55, "u55_tx");
        check("u55_busy_done", {31'b0, tx_busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("u55_idle_tx", {31'b0, tx}, 32'd1);
            step();
        end

        // back-to-back frames with no idle gap
        addr  = 32'h0000_FF00;
        wdata = 32'h0000_0041;
        we    = 1'b1;
        step();
        wdata = 32'h0000_0042;
        step();
        we = 1'b0;
        frame(8'h41, "b2b_a");
        frame(8'h42, "b2b_b");
        check("b2b_busy_done", {31'b0, tx_busy}, 32'd0);
        check("b2b_tx_idle", {31'b0, tx}, 32'd1);

        // overflow: six pushes into a depth-4 FIFO, one pop in between
        addr  = 32'h0000_FF00;
        we    = 1'b1;
        wdata = 32'h0000_0061;
        step();
        wdata = 32'h0000_0062;
        step();
        check("ovf_start_tx", {31'b0, tx}, 32'd0);
        n = 0;
        for (int i = 3; i <= 6; i++) begin
            wdata = 32'h0000_0060 + i;
            step();
            n++;
        end
        we   = 1'b0;
        addr = 32'h0000_FF04;
        #1 check("ovf_status_full", rdata, 32'd7);
        wdata = 32'h0000_0004;
        we    = 1'b1;
        step();
        n++;
        we = 1'b0;
        #1 check("ovf_cleared", rdata, 32'd3);
        while (tx_busy && n < 2000) begin
            step();
            n++;
        end
        check("ovf_drain_busy", {31'b0, tx_busy}, 32'd0);
        check("ovf_drain_cycles", 32'(n), 32'd800);
        #1 check("ovf_status_idle", rdata, 32'd0);

        // reset in the middle of data bit 3 of 0xF0
        step();
        addr  = 32'h0000_FF00;
        wdata = 32'h0000_00F0;
        we    = 1'b1;
        step();
        we = 1'b0;
        step();
        repeat (70) step();
        check("mid_pre_tx", {31'b0, tx}, 32'd0);
        check("mid_pre_busy", {31'b0, tx_busy}, 32'd1);
        #1 resetn = 1'b0;
        #1 check("mid_rst_tx", {31'b0, tx}, 32'd1);
        check("mid_rst_busy", {31'b0, tx_busy}, 32'd0);
        addr = 32'h0000_FF04;
        #1 check("mid_rst_status", rdata, 32'd0);
        addr = 32'h0000_FF08;
        #1 check("mid_rst_cycle", rdata, 32'd0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            check("mid_after_tx", {31'b0, tx}, 32'd1);
            step();
        end
        check("mid_after_busy", {31'b0, tx_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
